// File: rtl/hood_ctrl_if.sv
// Range-hood controller bus: key pulses and time base in, state/indicators out.
interface hood_ctrl_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             tick;
  logic             key_power;
  logic             key_menu;
  logic             key_l1;
  logic             key_l2;
  logic             key_l3;
  logic             key_clean;
  logic [2:0]       state;
  logic [6:0]       led;
  logic [1:0]       fan_level;
  logic [CNT_W-1:0] time_left;
  logic             hurr_avail;
  logic             remind;

  modport master (
    output tick, key_power, key_menu, key_l1, key_l2, key_l3, key_clean,
    input  state, led, fan_level, time_left, hurr_avail, remind
  );

  modport slave (
    input  tick, key_power, key_menu, key_l1, key_l2, key_l3, key_clean,
    output state, led, fan_level, time_left, hurr_avail, remind
  );

endinterface

// File: rtl/hood_ctrl_fsm.sv
// Range-hood controller: power/standby, three fan levels, one-shot hurricane
// boost, self-clean cycle and delayed shutdown, all timed off a 1 Hz tick.
// Optional runtime clean-due reminder compiled in by HOOD_RUNTIME_REMIND_EN.
module hood_ctrl_fsm #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned HURR_T   = 60,
  parameter int unsigned RET_T    = 180,
  parameter int unsigned CLEAN_T  = 200,
  parameter int unsigned RUN_W    = 16,
  parameter int unsigned REMIND_T = 36000
) (
  input  logic        clk,
  input  logic        reset,
  hood_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_STBY  = 3'd1,
    S_L1    = 3'd2,
    S_L2    = 3'd3,
    S_L3    = 3'd4,
    S_CLEAN = 3'd5,
    S_RET   = 3'd6,
    S_BAD   = 3'd7
  } state_e;

  // Reject durations that do not fit the countdown or runtime counters.
  if (HURR_T == 0 || (64'(HURR_T) >> CNT_W) != 0 ||
      RET_T == 0 || (64'(RET_T) >> CNT_W) != 0 ||
      CLEAN_T == 0 || (64'(CLEAN_T) >> CNT_W) != 0 ||
      (64'(REMIND_T) >> RUN_W) != 0) begin : g_bad_param
    $error("hood_ctrl_fsm: duration parameter out of range");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tl_q, tl_d;
  logic             hurr_q, hurr_d;
  logic [1:0]       fan_q, fan_d;
  logic [6:0]       led_q, led_d;
  logic             l3_ok;
  logic             expire;
  logic [CNT_W-1:0] tl_dec;

  // Next-state, countdown and indicator decode; a key always beats a tick.
  always_comb begin
    state_d = state_q;
    tl_d    = tl_q;
    hurr_d  = hurr_q;
    l3_ok   = bus.key_l3 && hurr_q;
    expire  = bus.tick && (tl_q == CNT_W'(1));
    tl_dec  = (tl_q != '0) ? tl_q - CNT_W'(1) : tl_q;

    case (state_q)
      S_OFF: begin
        if (bus.key_power) begin
          state_d = S_STBY;
          hurr_d  = 1'b1;
        end
      end
      S_STBY: begin
        if (bus.key_power) begin
          state_d = S_OFF;
        end else if (l3_ok) begin
          state_d = S_L3;
          tl_d    = CNT_W'(HURR_T);
          hurr_d  = 1'b0;
        end else if (bus.key_l2) begin
          state_d = S_L2;
        end else if (bus.key_l1) begin
          state_d = S_L1;
        end else if (bus.key_clean) begin
          state_d = S_CLEAN;
          tl_d    = CNT_W'(CLEAN_T);
        end
      end
      S_L1, S_L2: begin
        if (bus.key_power) begin
          state_d = S_RET;
          tl_d    = CNT_W'(RET_T);
        end else if (l3_ok) begin
          state_d = S_L3;
          tl_d    = CNT_W'(HURR_T);
          hurr_d  = 1'b0;
        end else if (bus.key_l2) begin
          state_d = S_L2;
        end else if (bus.key_l1) begin
          state_d = S_L1;
        end else if (bus.key_menu) begin
          state_d = S_STBY;
        end
      end
      S_L3: begin
        if (bus.key_power) begin
          state_d = S_RET;
          tl_d    = CNT_W'(RET_T);
        end else if (expire) begin
          state_d = S_L2;
        end else if (bus.tick) begin
          tl_d = tl_dec;
        end
      end
      S_CLEAN: begin
        if (bus.key_power) begin
          state_d = S_OFF;
        end else if (expire) begin
          state_d = S_STBY;
        end else if (bus.tick) begin
          tl_d = tl_dec;
        end
      end
      S_RET: begin
        if (bus.key_power) begin
          state_d = S_OFF;
        end else if (bus.key_l2) begin
          state_d = S_L2;
        end else if (bus.key_l1) begin
          state_d = S_L1;
        end else if (expire) begin
          state_d = S_OFF;
        end else if (bus.tick) begin
          tl_d = tl_dec;
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase

    // Untimed states never carry a stale countdown.
    if (state_d != S_L3 && state_d != S_CLEAN && state_d != S_RET) begin
      tl_d = '0;
    end

    case (state_d)
      S_L1, S_CLEAN, S_RET: fan_d = 2'd1;
      S_L2:                 fan_d = 2'd2;
      S_L3:                 fan_d = 2'd3;
      default:              fan_d = 2'd0;
    endcase

    for (int i = 0; i < 7; i++) begin
      led_d[i] = (3'(state_d) == 3'(i));
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_OFF;
      tl_q    <= '0;
      hurr_q  <= 1'b0;
      fan_q   <= 2'd0;
      led_q   <= 7'b0000001;
    end else begin
      state_q <= state_d;
      tl_q    <= tl_d;
      hurr_q  <= hurr_d;
      fan_q   <= fan_d;
      led_q   <= led_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.led        = led_q;
  assign bus.fan_level  = fan_q;
  assign bus.time_left  = tl_q;
  assign bus.hurr_avail = hurr_q;

`ifdef HOOD_RUNTIME_REMIND_EN
  logic [RUN_W-1:0] run_q, run_d;
  logic             remind_q, remind_d;
  logic             clean_done;

  // Fan runtime accumulator; only a completed self-clean resets it.
  always_comb begin
    run_d      = run_q;
    remind_d   = remind_q;
    clean_done = (state_q == S_CLEAN) && !bus.key_power && expire;
    if (clean_done) begin
      run_d    = '0;
      remind_d = 1'b0;
    end else begin
      if (bus.tick && fan_q != 2'd0 && state_q != S_CLEAN && run_q != '1) begin
        run_d = run_q + RUN_W'(1);
      end
      remind_d = remind_q | (run_d >= RUN_W'(REMIND_T));
    end
  end

  // Runtime counter and reminder flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q    <= '0;
      remind_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      remind_q <= remind_d;
    end
  end

  assign bus.remind = remind_q;
`else
  assign bus.remind = 1'b0;
`endif

endmodule

// File: tb/tb_hood_ctrl_fsm.sv
// Scenario bench for hood_ctrl_fsm; remind expectations follow HOOD_RUNTIME_REMIND_EN.
module tb_hood_ctrl_fsm;

  localparam logic [5:0] K_NONE = 6'b000000;
  localparam logic [5:0] K_P    = 6'b100000;
  localparam logic [5:0] K_L3   = 6'b010000;
  localparam logic [5:0] K_L2   = 6'b001000;
  localparam logic [5:0] K_L1   = 6'b000100;
  localparam logic [5:0] K_CL   = 6'b000010;
  localparam logic [5:0] K_MN   = 6'b000001;

  typedef struct {
    logic       rst;
    logic [5:0] keys;
    logic       tick;
    logic [2:0] st;
    logic [1:0] fan;
    logic [7:0] tl;
    logic       ha;
    logic       rm;
  } vec_t;

  typedef struct packed {
    logic [2:0] st;
    logic [6:0] led;
    logic [1:0] fan;
    logic [7:0] tl;
    logic       ha;
    logic       rm;
  } obs_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  obs_t sb[$];

  hood_ctrl_if #(.CNT_W(8)) bus ();

  hood_ctrl_fsm #(
    .CNT_W(8), .HURR_T(3), .RET_T(2), .CLEAN_T(4), .RUN_W(16), .REMIND_T(5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [5:0] k, logic t, logic [2:0] st,
                              logic [1:0] f, logic [7:0] tl, logic ha, logic rm);
    vec_t v;
    v.rst = r; v.keys = k; v.tick = t; v.st = st; v.fan = f; v.tl = tl; v.ha = ha; v.rm = rm;
    return v;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = {bus.state, bus.led, bus.fan_level, bus.time_left, bus.hurr_avail, bus.remind};
    return o;
  endfunction

  // Drive one cycle of stimulus and queue the outputs it must produce.
  task automatic drive(input vec_t v);
    obs_t e;
    logic [6:0] one;
    @(negedge clk);
    reset    = v.rst;
    bus.tick = v.tick;
    {bus.key_power, bus.key_l3, bus.key_l2, bus.key_l1, bus.key_clean, bus.key_menu} = v.keys;
    one   = 7'b0000001;
    e.st  = v.st;
    e.led = one << v.st;
    e.fan = v.fan;
    e.tl  = v.tl;
    e.ha  = v.ha;
`ifdef HOOD_RUNTIME_REMIND_EN
    e.rm  = v.rm;
`else
    e.rm  = 1'b0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    bus.tick = 1'b0;
    {bus.key_power, bus.key_l3, bus.key_l2, bus.key_l1, bus.key_clean, bus.key_menu} = K_NONE;
  endtask

  task automatic test_reset();
    vec_t v[$];
    obs_t e, o;
    v.push_back(mk(1, K_P,   1, 0, 0, 0, 0, 0));
    v.push_back(mk(1, K_L3,  1, 0, 0, 0, 0, 0));
    v.push_back(mk(0, K_L1,  0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, K_CL,  1, 0, 0, 0, 0, 0));
    v.push_back(mk(0, K_L3,  0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got st=%0d led=%b fan=%0d tl=%0d ha=%b rm=%b, expected st=%0d led=%b fan=%0d tl=%0d ha=%b rm=%b",
                 i, o.st, o.led, o.fan, o.tl, o.ha, o.rm, e.st, e.led, e.fan, e.tl, e.ha, e.rm);
      end
    end
  endtask

  task automatic test_hurricane();
    vec_t v[$];
    obs_t e, o;
    v.push_back(mk(1, K_NONE,    0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, K_P,       0, 1, 0, 0, 1, 0));
    v.push_back(mk(0, K_L3,      0, 4, 3, 3, 0, 0));
    v.push_back(mk(0, K_NONE,    1, 4, 3, 2, 0, 0));
    v.push_back(mk(0, K_NONE,    1, 4, 3, 1, 0, 0));
    v.push_back(mk(0, K_NONE,    1, 3, 2, 0, 0, 0));
    v.push_back(mk(0, K_L3|K_L1, 0, 2, 1, 0, 0, 0));
    v.push_back(mk(0, K_L3|K_L2, 0, 3, 2, 0, 0, 0));
    v.push_back(mk(0, K_NONE,    1, 3, 2, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL hurricane[%0d]: got st=%0d led=%b fan=%0d tl=%0d ha=%b rm=%b, expected st=%0d led=%b fan=%0d tl=%0d ha=%b rm=%b",
                 i, o.st, o.led, o.fan, o.tl, o.ha, o.rm, e.st, e.led, e.fan, e.tl, e.ha, e.rm);
      end
    end
  endtask

  task automatic test_priority();
    vec_t v[$];
    obs_t e, o;
    v.push_back(mk(1, K_NONE,               0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, K_P,                  0, 1, 0, 0, 1, 0));
    v.push_back(mk(0, K_L2|K_L1|K_CL|K_MN,  0, 3, 2, 0, 1, 0));
    v.push_back(mk(0, K_L1|K_CL|K_MN,       0, 2, 1, 0, 1, 0));
    v.push_back(mk(0, K_MN,                 0, 1, 0, 0, 1, 0));
    v.push_back(mk(0, K_P|K_L3|K_L1,        0, 0, 0, 0, 1, 0));
    v.push_back(mk(0, K_P,                  0, 1, 0, 0, 1, 0));
    v.push_back(mk(0, K_CL,                 0, 5, 1, 4, 1, 0));
    v.push_back(mk(0, K_L1,                 0, 5, 1, 4, 1, 0));
    v.push_back(mk(0, K_NONE,               1, 5, 1, 3, 1, 0));
    v.push_back(mk(0, K_P,                  0, 0, 0, 0, 1, 0));
    foreach (v[i]) begin
      drive(v[i]);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL priority[%0d]: got st=%0d led=%b fan=%0d tl=%0d ha=%b rm=%b, expected st=%0d led=%b fan=%0d tl=%0d ha=%b rm=%b",
                 i, o.st, o.led, o.fan, o.tl, o.ha, o.rm, e.st, e.led, e.fan, e.tl, e.ha, e.rm);
      end
    end
  endtask

  task automatic test_ret();
    vec_t v[$];
    obs_t e, o;
    v.push_back(mk(1, K_NONE, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, K_P,    0, 1, 0, 0, 1, 0));
    v.push_back(mk(0, K_L3,   0, 4, 3, 3, 0, 0));
    v.push_back(mk(0, K_NONE, 1, 4, 3, 2, 0, 0));
    v.push_back(mk(0, K_L1,   0, 4, 3, 2, 0, 0));
    v.push_back(mk(0, K_P,    0, 6, 1, 2, 0, 0));
    v.push_back(mk(0, K_NONE, 1, 6, 1, 1, 0, 0));
    v.push_back(mk(0, K_NONE, 1, 0, 0, 0, 0, 0));
    v.push_back(mk(0, K_P,    0, 1, 0, 0, 1, 0));
    foreach (v[i]) begin
      drive(v[i]);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ret[%0d]: got st=%0d led=%b fan=%0d tl=%0d ha=%b rm=%b, expected st=%0d led=%b fan=%0d tl=%0d ha=%b rm=%b",
                 i, o.st, o.led, o.fan, o.tl, o.ha, o.rm, e.st, e.led, e.fan, e.tl, e.ha, e.rm);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    obs_t e, o;
    v.push_back(mk(1, K_NONE, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, K_P,    0, 1, 0, 0, 1, 0));
    v.push_back(mk(0, K_CL,   0, 5, 1, 4, 1, 0));
    for (int t = 3; t >= 1; t--) v.push_back(mk(0, K_NONE, 1, 5, 1, 8'(t), 1, 0));
    v.push_back(mk(0, K_CL,   1, 1, 0, 0, 1, 0));
    v.push_back(mk(0, K_L3,   0, 4, 3, 3, 0, 0));
    v.push_back(mk(0, K_P,    0, 6, 1, 2, 0, 0));
    v.push_back(mk(0, K_NONE, 1, 6, 1, 1, 0, 0));
    v.push_back(mk(0, K_L2,   1, 3, 2, 0, 0, 0));
    v.push_back(mk(0, K_NONE, 1, 3, 2, 0, 0, 0));
    v.push_back(mk(0, K_P,    0, 6, 1, 2, 0, 0));
    v.push_back(mk(0, K_P,    1, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got st=%0d led=%b fan=%0d tl=%0d ha=%b rm=%b, expected st=%0d led=%b fan=%0d tl=%0d ha=%b rm=%b",
                 i, o.st, o.led, o.fan, o.tl, o.ha, o.rm, e.st, e.led, e.fan, e.tl, e.ha, e.rm);
      end
    end
  endtask

  task automatic test_remind();
    vec_t v[$];
    obs_t e, o;
    v.push_back(mk(1, K_NONE, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, K_P,    0, 1, 0, 0, 1, 0));
    v.push_back(mk(0, K_L1,   0, 2, 1, 0, 1, 0));
    for (int t = 1; t <= 5; t++) v.push_back(mk(0, K_NONE, 1, 2, 1, 0, 1, (t == 5)));
    v.push_back(mk(0, K_P,    0, 6, 1, 2, 1, 1));
    v.push_back(mk(0, K_P,    0, 0, 0, 0, 1, 1));
    v.push_back(mk(0, K_P,    0, 1, 0, 0, 1, 1));
    v.push_back(mk(0, K_CL,   0, 5, 1, 4, 1, 1));
    v.push_back(mk(0, K_NONE, 1, 5, 1, 3, 1, 1));
    v.push_back(mk(1, K_P,    1, 0, 0, 0, 0, 0));
    v.push_back(mk(0, K_P,    0, 1, 0, 0, 1, 0));
    v.push_back(mk(0, K_L1,   0, 2, 1, 0, 1, 0));
    for (int t = 1; t <= 5; t++) v.push_back(mk(0, K_NONE, 1, 2, 1, 0, 1, (t == 5)));
    v.push_back(mk(0, K_MN,   0, 1, 0, 0, 1, 1));
    v.push_back(mk(0, K_CL,   0, 5, 1, 4, 1, 1));
    for (int t = 3; t >= 1; t--) v.push_back(mk(0, K_NONE, 1, 5, 1, 8'(t), 1, 1));
    v.push_back(mk(0, K_CL,   1, 1, 0, 0, 1, 0));
    v.push_back(mk(0, K_L1,   0, 2, 1, 0, 1, 0));
    for (int t = 1; t <= 4; t++) v.push_back(mk(0, K_NONE, 1, 2, 1, 0, 1, 0));
    foreach (v[i]) begin
      drive(v[i]);
      e = sb.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL remind[%0d]: got st=%0d led=%b fan=%0d tl=%0d ha=%b rm=%b, expected st=%0d led=%b fan=%0d tl=%0d ha=%b rm=%b",
                 i, o.st, o.led, o.fan, o.tl, o.ha, o.rm, e.st, e.led, e.fan, e.tl, e.ha, e.rm);
      end
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    bus.tick      = 1'b0;
    bus.key_power = 1'b0;
    bus.key_menu  = 1'b0;
    bus.key_l1    = 1'b0;
    bus.key_l2    = 1'b0;
    bus.key_l3    = 1'b0;
    bus.key_clean = 1'b0;
    test_reset();
    test_hurricane();
    test_priority();
    test_ret();
    test_back_to_back();
    test_remind();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
